// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline controller: FSM state encodings,
//   the width of the flush down-counter and the NOP instruction word that
//   the pipeline registers load while hold_flag_o is asserted.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_FLUSH = 2'd1,
    CTRL_PEND  = 2'd2
  } ctrl_state_e;

  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 7.
  localparam int CTRL_CNT_W = 3;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// ctrl_perf_cnt
//   Two free-running 32-bit event counters for the pipeline controller.
//   Each counter increments by one on every clock in which its enable is
//   high and wraps from 0xFFFFFFFF to 0.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset, clears both counters
//   i_flush_inc  in   count one flush (hold) cycle
//   i_stall_inc  in   count one stall cycle
//   o_flush_cnt  out  flush-cycle count
//   o_stall_cnt  out  stall-cycle count
module ctrl_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [1:0]  w_inc;
  logic [31:0] r_cnt [2];

  assign w_inc = {i_stall_inc, i_flush_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[gi] <= '0;
        end else if (w_inc[gi]) begin
          r_cnt[gi] <= r_cnt[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign o_flush_cnt = r_cnt[0];
  assign o_stall_cnt = r_cnt[1];

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central pipeline controller. Turns ex redirect requests and busy
//   requests into the PC redirect, the PC/if_id freeze and the hold flag
//   that loads NOP/zero into the pipeline registers. A jump arriving while
//   an instruction fetch is in flight is parked and replayed once the bus
//   frees.
//
//   Optional feature macro: CTRL_PERF_CNT_EN
//     defined   -> flush/stall cycle counters are built (ctrl_perf_cnt)
//     undefined -> perf outputs tied to zero, no counter flops
//
// Parameters:
//   FLUSH_CYCLES  cycles of hold_flag_o per accepted jump (1..7), accept
//                 cycle included
//
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   jump_en_i         in   ex redirect request (single-cycle pulse)
//   jump_addr_i       in   redirect target, valid with jump_en_i
//   ex_stall_req_i    in   ex multi-cycle op busy (level)
//   mem_wait_i        in   instruction fetch in flight (level)
//   jump_en_o         out  pc_reg loads jump_addr_o this cycle
//   jump_addr_o       out  redirect target, 0 when jump_en_o=0
//   hold_flag_o       out  if_id/id_ex load NOP/zero
//   stall_pc_o        out  pc_reg/if_id hold their value
//   perf_flush_cnt_o  out  hold cycle count (feature only)
//   perf_stall_cnt_o  out  stall cycle count (feature only)
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_stall_req_i,
  input  logic        mem_wait_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_flag_o,
  output logic        stall_pc_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [31:0] perf_stall_cnt_o
);

  import pipe_ctrl_pkg::*;

  localparam logic [CTRL_CNT_W-1:0] FLUSH_INIT  = CTRL_CNT_W'(FLUSH_CYCLES - 1);
  localparam bit                    MULTI_FLUSH = (FLUSH_CYCLES > 1);

  ctrl_state_e           r_state;
  logic [CTRL_CNT_W-1:0] r_cnt;
  logic [31:0]           r_pend_addr;

  logic w_idle;
  logic w_flush;
  logic w_pend;
  logic w_acc_now;
  logic w_acc_pend;
  logic w_jump;
  logic w_hold;
  logic w_stall;

  assign w_idle  = (r_state == CTRL_IDLE);
  assign w_flush = (r_state == CTRL_FLUSH);
  assign w_pend  = (r_state == CTRL_PEND);

  // The two ways a redirect reaches pc_reg: straight through when the bus
  // is free, or replayed from the parked address once it frees.
  assign w_acc_now  = w_idle & jump_en_i & ~mem_wait_i;
  assign w_acc_pend = w_pend & ~mem_wait_i;

  // All outputs are gated with rst_n so they drop the moment reset is
  // asserted, independent of whatever the inputs are doing.
  assign w_jump = rst_n & (w_acc_now | w_acc_pend);

  // Any jump seen in IDLE (accepted or parked) squashes the younger
  // instructions immediately; PEND and FLUSH keep squashing.
  assign w_hold = rst_n & ((w_idle & jump_en_i) | w_pend | w_flush | ex_stall_req_i);

  // The PC is frozen whenever the fetch bus is busy or ex is busy. In PEND
  // this drops exactly on the replay cycle, since that is the first cycle
  // with mem_wait_i low.
  assign w_stall = rst_n & (mem_wait_i | ex_stall_req_i);

  assign jump_en_o   = w_jump;
  assign jump_addr_o = w_jump ? (w_pend ? r_pend_addr : jump_addr_i) : '0;
  assign hold_flag_o = w_hold;
  assign stall_pc_o  = w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CTRL_IDLE;
      r_cnt       <= '0;
      r_pend_addr <= '0;
    end else begin
      case (r_state)
        CTRL_IDLE: begin
          if (jump_en_i) begin
            if (mem_wait_i) begin
              r_pend_addr <= jump_addr_i;
              r_state     <= CTRL_PEND;
            end else if (MULTI_FLUSH) begin
              r_cnt   <= FLUSH_INIT;
              r_state <= CTRL_FLUSH;
            end
          end
        end
        CTRL_PEND: begin
          // jump_en_i is deliberately ignored here: ex was flushed when
          // the jump was parked, so it cannot legally issue another.
          if (!mem_wait_i) begin
            r_pend_addr <= '0;
            if (MULTI_FLUSH) begin
              r_cnt   <= FLUSH_INIT;
              r_state <= CTRL_FLUSH;
            end else begin
              r_state <= CTRL_IDLE;
            end
          end
        end
        CTRL_FLUSH: begin
          // ex holds a bubble during FLUSH, so jump_en_i is not looked at.
          r_cnt <= r_cnt - CTRL_CNT_W'(1);
          if (r_cnt == CTRL_CNT_W'(1)) begin
            r_state <= CTRL_IDLE;
          end
        end
        default: begin
          r_state <= CTRL_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A redirect request while a jump is parked means ex was not flushed.
  always @(posedge clk) begin
    if (rst_n && w_pend) begin
      assert (!jump_en_i);
    end
  end
`endif

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush_inc (w_hold),
    .i_stall_inc (w_stall),
    .o_flush_cnt (perf_flush_cnt_o),
    .o_stall_cnt (perf_stall_cnt_o)
  );
`else
  assign perf_flush_cnt_o = 32'b0;
  assign perf_stall_cnt_o = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl (FLUSH_CYCLES=2). Inputs change 1 ns after
//   the rising edge; outputs are compared at the falling edge. Each cycle's
//   outputs are packed as {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o}.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_stall_req_i;
  logic        mem_wait_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_flag_o;
  logic        stall_pc_o;
  logic [31:0] perf_flush_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .jump_en_i        (jump_en_i),
    .jump_addr_i      (jump_addr_i),
    .ex_stall_req_i   (ex_stall_req_i),
    .mem_wait_i       (mem_wait_i),
    .jump_en_o        (jump_en_o),
    .jump_addr_o      (jump_addr_o),
    .hold_flag_o      (hold_flag_o),
    .stall_pc_o       (stall_pc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: apply after the rising edge, return at the
  // falling edge so the caller can sample settled outputs.
  task automatic cyc(input logic jen, input logic [31:0] addr,
                     input logic stl, input logic mw);
    @(posedge clk);
    #1;
    jump_en_i      = jen;
    jump_addr_i    = addr;
    ex_stall_req_i = stl;
    mem_wait_i     = mw;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [34:0] obs;
    rst_n          = 1'b0;
    jump_en_i      = 1'b1;
    jump_addr_i    = 32'hDEAD_BEEF;
    ex_stall_req_i = 1'b1;
    mem_wait_i     = 1'b1;
    repeat (2) @(negedge clk);
    obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
    total++;
    if (obs !== 35'h0) begin
      bad++;
      $display("FAIL reset_hold: got=%h want=%h", obs, 35'h0);
    end
    jump_en_i      = 1'b0;
    jump_addr_i    = 32'h0;
    ex_stall_req_i = 1'b0;
    mem_wait_i     = 1'b0;
    rst_n          = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
    total++;
    if (obs !== 35'h0) begin
      bad++;
      $display("FAIL reset_first_cycle: got=%h want=%h", obs, 35'h0);
    end
    total++;
    if ({perf_flush_cnt_o, perf_stall_cnt_o} !== 64'h0) begin
      bad++;
      $display("FAIL reset_perf: got=%h want=0", {perf_flush_cnt_o, perf_stall_cnt_o});
    end
  endtask

  task automatic test_jump_now;
    logic [34:0] obs;
    logic [34:0] exp [3];
    exp[0] = {1'b1, 1'b1, 1'b0, 32'h0000_0100};
    exp[1] = {1'b0, 1'b1, 1'b0, 32'h0};
    exp[2] = 35'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0);
      else        cyc(1'b0, 32'h0, 1'b0, 1'b0);
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL jump_now_c%0d: got=%h want=%h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_ex_stall;
    logic [34:0] obs;
    logic [34:0] exp;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0, (i < 5), 1'b0);
      exp = (i < 5) ? {1'b0, 1'b1, 1'b1, 32'h0} : 35'h0;
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ex_stall_c%0d: got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_perf;
    logic [63:0] exp;
`ifdef CTRL_PERF_CNT_EN
    exp = {32'd7, 32'd5};
`else
    exp = 64'h0;
`endif
    total++;
    if ({perf_flush_cnt_o, perf_stall_cnt_o} !== exp) begin
      bad++;
      $display("FAIL perf_counts: got flush=%0d stall=%0d want flush=%0d stall=%0d",
               perf_flush_cnt_o, perf_stall_cnt_o, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_jump_pend;
    logic [34:0] obs;
    logic [34:0] exp [6];
    exp[0] = {1'b0, 1'b1, 1'b1, 32'h0};
    exp[1] = {1'b0, 1'b1, 1'b1, 32'h0};
    exp[2] = {1'b0, 1'b1, 1'b1, 32'h0};
    exp[3] = {1'b1, 1'b1, 1'b0, 32'h0000_0200};
    exp[4] = {1'b0, 1'b1, 1'b0, 32'h0};
    exp[5] = 35'h0;
    for (int i = 0; i < 6; i++) begin
      // jump_addr_i is driven with junk after the request to prove the
      // replay uses the parked address.
      if (i == 0) cyc(1'b1, 32'h0000_0200, 1'b0, 1'b1);
      else        cyc(1'b0, 32'hFFFF_0000, 1'b0, (i < 3));
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL jump_pend_c%0d: got=%h want=%h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_flush_ignore;
    logic [34:0] obs;
    logic [34:0] exp [3];
    exp[0] = {1'b1, 1'b1, 1'b0, 32'h0000_0400};
    exp[1] = {1'b0, 1'b1, 1'b0, 32'h0};
    exp[2] = 35'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      cyc(1'b1, 32'h0000_0400, 1'b0, 1'b0);
      else if (i == 1) cyc(1'b1, 32'h0000_0500, 1'b0, 1'b0);
      else             cyc(1'b0, 32'h0, 1'b0, 1'b0);
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL flush_ignore_c%0d: got=%h want=%h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_jump_with_stall;
    logic [34:0] obs;
    logic [34:0] exp [3];
    exp[0] = {1'b1, 1'b1, 1'b1, 32'h0000_0600};
    exp[1] = {1'b0, 1'b1, 1'b0, 32'h0};
    exp[2] = 35'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cyc(1'b1, 32'h0000_0600, 1'b1, 1'b0);
      else        cyc(1'b0, 32'h0, 1'b0, 1'b0);
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL jump_with_stall_c%0d: got=%h want=%h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_mem_wait_idle;
    logic [34:0] obs;
    logic [34:0] exp;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, (i < 2));
      exp = (i < 2) ? {1'b0, 1'b0, 1'b1, 32'h0} : 35'h0;
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mem_wait_idle_c%0d: got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_in_pend;
    logic [34:0] obs;
    logic [34:0] exp_pend;
    exp_pend = {1'b0, 1'b1, 1'b1, 32'h0};
    cyc(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
    total++;
    if (obs !== exp_pend) begin
      bad++;
      $display("FAIL rst_pend_parked: got=%h want=%h", obs, exp_pend);
    end
    #1;
    rst_n = 1'b0;
    #1;
    obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
    total++;
    if (obs !== 35'h0) begin
      bad++;
      $display("FAIL rst_pend_immediate: got=%h want=%h", obs, 35'h0);
    end
    repeat (2) @(negedge clk);
    mem_wait_i = 1'b0;
    rst_n      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      obs = {jump_en_o, hold_flag_o, stall_pc_o, jump_addr_o};
      total++;
      if (obs !== 35'h0) begin
        bad++;
        $display("FAIL rst_pend_no_replay_c%0d: got=%h want=%h", i, obs, 35'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump_now();
    test_ex_stall();
    test_perf();
    test_jump_pend();
    test_flush_ignore();
    test_jump_with_stall();
    test_mem_wait_idle();
    test_reset_in_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
